// File: rtl/line_buffer_ctrl_if.sv
// Renderer-side handshake of the scanline buffer controller.
//   line_req  : one-cycle pulse asking the renderer to produce line line_num
//   line_num  : Atari line (0..239) to render, held until the next line_req
//   wr_valid  : renderer presents a pixel on wr_color
//   wr_color  : 7-bit colour index of the presented pixel
//   wr_ready  : controller accepts the presented pixel this cycle
// master = controller side, slave = renderer side.
interface line_buffer_ctrl_if;
    logic       line_req;
    logic [7:0] line_num;
    logic       wr_valid;
    logic [6:0] wr_color;
    logic       wr_ready;

    modport master (
        output line_req, line_num, wr_ready,
        input  wr_valid, wr_color
    );

    modport slave (
        input  line_req, line_num, wr_ready,
        output wr_valid, wr_color
    );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Ping-pong scanline buffer between the Atari line renderer and the HDMI
// output. The renderer fills the back bank with one 160-pixel line while the
// front bank is shown scaled 4x horizontally and 2x vertically inside the
// 720x480 image. Banks swap at even image rows; a line that is not complete
// by then is dropped and counted as an underrun.
//   clk, reset_n   : pixel clock, asynchronous active-low reset
//   hpos, vpos     : beam position from the HDMI block
//   render         : line request / pixel write handshake (master side)
//   color          : colour index for the current beam position
//   frame_start    : one-cycle pulse when Atari line 0 is swapped in
//   underrun_count : saturating count of missed swaps
module line_buffer_ctrl #(
    parameter int         WIDTH   = 858,
    parameter int         HEIGHT  = 525,
    parameter int         H_START = 40,
    parameter logic [6:0] BORDER  = 7'h00
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [9:0]          hpos,
    input  logic [9:0]          vpos,
    line_buffer_ctrl_if.master  render,
    output logic [6:0]          color,
    output logic                frame_start,
    output logic [7:0]          underrun_count
);
    localparam logic [9:0] W_LAST = 10'(WIDTH - 1);
    localparam logic [9:0] V_LAST = 10'(HEIGHT - 1);
    localparam logic [9:0] H_S    = 10'(H_START);
    localparam logic [9:0] H_E    = 10'(H_START + 640);
    localparam logic [9:0] ROWS   = 10'd480;

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, FULL = 2'd2} fill_state_e;

    fill_state_e state, state_n;
    logic        rd_bank, disp_valid, armed, line_req_q;
    logic [7:0]  line_num_q, wr_addr;
    logic [6:0]  bank0 [160];
    logic [6:0]  bank1 [160];

    logic        beam, swap_ev, pre_ev, swap_ok, underrun, req, wr_en;
    logic [9:0]  nv, h_nx, v_nx;
    logic [8:0]  next_line;
    logic [7:0]  req_num, rd_idx;
    logic        bank_nx, in_win;
    logic [6:0]  rd_data;

    // Beam events happen on the last column of every row.
    assign beam    = (hpos == W_LAST);
    assign nv      = (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
    // Swaps are ignored until the first prefetch after reset so a reset in
    // mid-frame neither requests lines nor counts underruns before line 0.
    assign swap_ev = beam && armed && (nv < ROWS) && !nv[0];
    assign pre_ev  = beam && (nv == V_LAST);
    assign swap_ok  = swap_ev && (state == FULL);
    assign underrun = swap_ev && (state != FULL);
    assign next_line = nv[9:1] + 9'd1;

    // Next-state / request logic. A request always (re)starts a fill, which
    // also covers the abort cases: underrun swap and prefetch in FILL/FULL.
    always_comb begin
        req     = 1'b0;
        req_num = line_num_q;
        state_n = state;
        if (pre_ev) begin
            req     = 1'b1;
            req_num = 8'd0;
        end else if (swap_ev && next_line < 9'd240) begin
            req     = 1'b1;
            req_num = next_line[7:0];
        end
        // A pixel arriving in an event cycle belongs to the aborted line.
        wr_en = (state == FILL) && render.wr_valid && !req && !swap_ev;
        if (req)
            state_n = FILL;
        else if (swap_ev)
            state_n = IDLE;
        else if (wr_en && wr_addr == 8'd159)
            state_n = FULL;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed          <= 1'b0;
            rd_bank        <= 1'b0;
            disp_valid     <= 1'b0;
            wr_addr        <= 8'd0;
            line_req_q     <= 1'b0;
            line_num_q     <= 8'd0;
            frame_start    <= 1'b0;
            underrun_count <= 8'd0;
            color          <= BORDER;
        end else begin
            armed       <= armed | pre_ev;
            line_req_q  <= req;
            frame_start <= swap_ev && (nv == 10'd0);
            if (req)
                line_num_q <= req_num;
            if (req || swap_ev)
                wr_addr <= 8'd0;
            else if (wr_en)
                wr_addr <= wr_addr + 8'd1;
            if (swap_ok) begin
                rd_bank    <= ~rd_bank;
                disp_valid <= 1'b1;
            end
            if (underrun && underrun_count != 8'hFF)
                underrun_count <= underrun_count + 8'd1;
            color <= in_win ? rd_data : BORDER;
        end
    end

    // Writes go to the bank not being displayed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (rd_bank)
                bank0[wr_addr] <= render.wr_color;
            else
                bank1[wr_addr] <= render.wr_color;
        end
    end

    // Readout looks one pixel ahead so the registered colour lines up with
    // hpos. The look-ahead uses the post-swap bank, so pixel 0 of a new row
    // already reads the freshly swapped line.
    assign h_nx    = beam ? 10'd0 : hpos + 10'd1;
    assign v_nx    = beam ? nv : vpos;
    assign bank_nx = rd_bank ^ swap_ok;
    assign in_win  = (disp_valid | swap_ok) && (v_nx < ROWS) &&
                     (h_nx >= H_S) && (h_nx < H_E);
    assign rd_idx  = in_win ? 8'((h_nx - H_S) >> 2) : 8'd0;
    assign rd_data = bank_nx ? bank1[rd_idx] : bank0[rd_idx];

    assign render.line_req = line_req_q;
    assign render.line_num = line_num_q;
    assign render.wr_ready = (state == FILL);
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl. The beam position is driven directly
// so only the rows of interest are visited; expected pixels come from a
// per-line value pattern known to the bench.
module tb_line_buffer_ctrl;
    localparam int         WIDTH   = 858;
    localparam int         HEIGHT  = 525;
    localparam int         H_START = 40;
    localparam logic [6:0] BORDER  = 7'h00;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] hpos = '0;
    logic [9:0] vpos = '0;
    logic [6:0] color;
    logic       frame_start;
    logic [7:0] underrun_count;

    line_buffer_ctrl_if rif();

    int n_cmp = 0;
    int n_bad = 0;
    int lr_pulses = 0;
    int fs_pulses = 0;

    line_buffer_ctrl #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .H_START(H_START), .BORDER(BORDER)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .hpos(hpos),
        .vpos(vpos),
        .render(rif),
        .color(color),
        .frame_start(frame_start),
        .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rif.line_req)  lr_pulses++;
        if (frame_start)   fs_pulses++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] line_val(input int k, input int i);
        return 7'((k * 16 + i) & 127);
    endfunction

    function automatic logic [6:0] exp_px(input int k, input int h);
        if (k < 0 || h < H_START || h >= H_START + 640)
            return BORDER;
        return line_val(k, (h - H_START) >> 2);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle on the last column of row v, then park on column 0 of the next row.
    task automatic beam(input int v);
        hpos = 10'(WIDTH - 1);
        vpos = 10'(v);
        step();
        hpos = 10'd0;
        vpos = 10'((v == HEIGHT - 1) ? 0 : v + 1);
    endtask

    task automatic fill(input int k, input int n);
        int acc = 0;
        int cyc = 0;
        while (acc < n && cyc < 1000) begin
            rif.wr_valid = 1'b1;
            rif.wr_color = line_val(k, acc);
            if (rif.wr_ready) acc++;
            step();
            cyc++;
        end
        rif.wr_valid = 1'b0;
        chk("fill_accepted", acc, n);
    endtask

    // Scan pixels 1..719 of row v; k < 0 means the whole row is border.
    task automatic check_row(input int v, input int k);
        vpos = 10'(v);
        hpos = 10'd0;
        step();
        for (int h = 1; h < 720; h++) begin
            hpos = 10'(h);
            chk($sformatf("pix r%0d h%0d", v, h), color, exp_px(k, h));
            step();
        end
        hpos = 10'd0;
    endtask

    initial begin
        int lr_base, fs_base, acc, cyc, raw;
        logic [6:0] extra;
        rif.wr_valid = 1'b0;
        rif.wr_color = 7'd0;

        // Reset values
        repeat (3) step();
        chk("rst_line_req", rif.line_req, 0);
        chk("rst_line_num", rif.line_num, 0);
        chk("rst_wr_ready", rif.wr_ready, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_underrun", underrun_count, 0);
        chk("rst_color", color, BORDER);
        reset_n = 1'b1;
        step();

        // Frame 1: ideal renderer
        lr_base = lr_pulses;
        fs_base = fs_pulses;
        beam(523);
        chk("pre_line_req", rif.line_req, 1);
        chk("pre_line_num", rif.line_num, 0);
        chk("pre_wr_ready", rif.wr_ready, 1);
        chk("pre_frame_start", frame_start, 0);
        step();
        chk("line_req_width", rif.line_req, 0);
        fill(0, 160);
        chk("full_ready_low", rif.wr_ready, 0);
        beam(524);
        chk("fs_pulse", frame_start, 1);
        chk("swap0_line_req", rif.line_req, 1);
        chk("swap0_line_num", rif.line_num, 1);
        step();
        chk("fs_width", frame_start, 0);
        check_row(0, 0);
        check_row(1, 0);

        // Bursty line 1: 160 accepted, then an extra pixel is refused
        acc = 0;
        cyc = 0;
        while (acc < 160 && cyc < 2000) begin
            rif.wr_valid = 1'($urandom_range(0, 1));
            rif.wr_color = line_val(1, acc);
            if (rif.wr_valid && rif.wr_ready) acc++;
            step();
            cyc++;
        end
        chk("burst_ready_low", rif.wr_ready, 0);
        extra = line_val(1, 0) ^ 7'h7F;
        rif.wr_valid = 1'b1;
        rif.wr_color = extra;
        repeat (4) step();
        rif.wr_valid = 1'b0;
        chk("burst_accepted", acc, 160);
        chk("burst_ready_still_low", rif.wr_ready, 0);
        beam(1);
        chk("swap2_line_num", rif.line_num, 2);
        check_row(2, 1);

        for (int k = 2; k < 240; k++) begin
            fill(k, 160);
            beam(2 * k - 1);
            if (k < 239)
                chk("seq_line_num", rif.line_num, k + 1);
            else
                chk("last_no_req", rif.line_req, 0);
        end
        chk("frame1_underrun", underrun_count, 0);
        chk("frame1_line_reqs", lr_pulses - lr_base, 240);
        chk("frame1_frame_starts", fs_pulses - fs_base, 1);
        check_row(479, 239);

        // Frame 2: renderer stalls on line 5
        beam(523);
        fill(0, 160);
        beam(524);
        for (int k = 1; k < 5; k++) begin
            fill(k, 160);
            beam(2 * k - 1);
        end
        fill(5, 100);
        beam(9);
        chk("stall_underrun", underrun_count, 1);
        chk("stall_line_req", rif.line_req, 1);
        chk("stall_line_num", rif.line_num, 6);
        check_row(10, 4);
        check_row(11, 4);
        fill(6, 160);
        beam(11);
        chk("recover_line_num", rif.line_num, 7);
        chk("recover_underrun", underrun_count, 1);
        check_row(12, 6);

        // Asynchronous reset mid-fill
        vpos = 10'd100;
        hpos = 10'd300;
        fill(7, 50);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_line_req", rif.line_req, 0);
        chk("arst_line_num", rif.line_num, 0);
        chk("arst_wr_ready", rif.wr_ready, 0);
        chk("arst_frame_start", frame_start, 0);
        chk("arst_underrun", underrun_count, 0);
        chk("arst_color", color, BORDER);
        step();
        reset_n = 1'b1;
        step();
        beam(99);
        chk("post_rst_no_req", rif.line_req, 0);
        chk("post_rst_no_underrun", underrun_count, 0);
        check_row(100, -1);
        beam(523);
        chk("post_rst_pre_req", rif.line_req, 1);
        chk("post_rst_pre_num", rif.line_num, 0);
        fill(0, 160);
        beam(524);
        chk("post_rst_fs", frame_start, 1);
        check_row(0, 0);

        // Underrun saturation; prefetch aborts do not count
        raw = 0;
        for (int pass = 0; pass < 2; pass++) begin
            beam(523);
            chk("sat_pre_req", rif.line_req, 1);
            if (pass == 0)
                chk("sat_pre_no_underrun", underrun_count, 0);
            for (int j = 0; j < 240 && raw < 300; j++) begin
                beam((j == 0) ? 524 : 2 * j - 1);
                raw++;
                if (raw == 1 || raw == 254 || raw == 255)
                    chk($sformatf("sat_count_%0d", raw), underrun_count, raw);
            end
        end
        chk("sat_final", underrun_count, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
